// File: rtl/vehicle_demand_detector.sv
// Road-demand front end: synchronises, debounces and stretches two loop detectors into sw[1:0].
// Optional vehicle counters are built when VEH_COUNT_EN is defined.
module vehicle_demand_detector #(
  parameter int DEBOUNCE_CYC  = 4,
  parameter int HOLD_SEC      = 3,
  parameter int MIN_DWELL_SEC = 2,
  parameter int STUCK_SEC     = 120
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       tick_1hz,
  input  logic       det_main,
  input  logic       det_branch,
  input  logic       fault_clr,
`ifdef VEH_COUNT_EN
  input  logic       cnt_clr,
  output logic [7:0] cnt_main,
  output logic [7:0] cnt_branch,
`endif
  output logic [1:0] sw,
  output logic       sw_chg,
  output logic [1:0] stuck
);

  typedef enum logic [1:0] {ABSENT, QUALIFY, PRESENT, HOLD} road_state_e;

  localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE_CYC - 1);
  localparam logic [5:0] HOLD_INIT  = 6'(HOLD_SEC);
  localparam logic [5:0] DWELL_INIT = 6'(MIN_DWELL_SEC);
  localparam logic [7:0] STUCK_MAX  = 8'(STUCK_SEC);
  localparam logic [7:0] STUCK_LAST = 8'(STUCK_SEC - 1);

  // Index 1 is the main road, index 0 the branch road, matching sw and stuck.
  logic [1:0]  sync1;
  logic [1:0]  s;
  road_state_e state_q [2];
  road_state_e state_d [2];
  logic [7:0]  deb_q   [2];
  logic [7:0]  deb_d   [2];
  logic [5:0]  hold_q  [2];
  logic [5:0]  hold_d  [2];
  logic [7:0]  stk_q   [2];
  logic [7:0]  stk_d   [2];
  logic [1:0]  stuck_set;
  logic [1:0]  demand;
  logic [5:0]  dwell_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= ABSENT;
        deb_q[i]   <= '0;
        hold_q[i]  <= '0;
        stk_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        deb_q[i]   <= deb_d[i];
        hold_q[i]  <= hold_d[i];
        stk_q[i]   <= stk_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      // NOTE: every comb output gets a default first so no path infers a latch.
      state_d[i]   = state_q[i];
      deb_d[i]     = deb_q[i];
      hold_d[i]    = hold_q[i];
      stk_d[i]     = stk_q[i];
      stuck_set[i] = 1'b0;
      unique case (state_q[i])
        ABSENT: begin
          if (s[i]) begin
            if (DEBOUNCE_CYC == 1) begin
              state_d[i] = PRESENT;
              stk_d[i]   = '0;
            end else begin
              state_d[i] = QUALIFY;
              deb_d[i]   = 8'd1;
            end
          end
        end
        QUALIFY: begin
          if (!s[i]) begin
            state_d[i] = ABSENT;
            deb_d[i]   = '0;
          end else if (deb_q[i] == DEB_LAST) begin
            state_d[i] = PRESENT;
            deb_d[i]   = '0;
            stk_d[i]   = '0;
          end else begin
            deb_d[i] = deb_q[i] + 8'd1;
          end
        end
        PRESENT: begin
          if (!s[i]) begin
            state_d[i] = HOLD;
            hold_d[i]  = HOLD_INIT;
          end else if (tick_1hz) begin
            if (stk_q[i] >= STUCK_LAST) begin
              stk_d[i]     = STUCK_MAX;
              stuck_set[i] = 1'b1;
            end else begin
              stk_d[i] = stk_q[i] + 8'd1;
            end
          end
        end
        HOLD: begin
          // A returning vehicle wins over a tick in the same cycle.
          if (s[i]) begin
            state_d[i] = PRESENT;
            stk_d[i]   = '0;
          end else if (tick_1hz) begin
            if (hold_q[i] == 6'd1) begin
              state_d[i] = ABSENT;
              hold_d[i]  = '0;
            end else begin
              hold_d[i] = hold_q[i] - 6'd1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      demand[i] = (state_q[i] == PRESENT) || (state_q[i] == HOLD) || stuck[i];
    end
  end

  // Synchronisers, sticky faults and the dwell-limited demand register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1   <= '0;
      s       <= '0;
      stuck   <= '0;
      sw      <= '0;
      sw_chg  <= 1'b0;
      dwell_q <= '0;
    end else begin
      sync1 <= {det_main, det_branch};
      s     <= sync1;
      stuck <= stuck_set | (stuck & ~{2{fault_clr}});
      if ((demand != sw) && (dwell_q == '0)) begin
        sw      <= demand;
        sw_chg  <= 1'b1;
        dwell_q <= DWELL_INIT;
      end else begin
        sw_chg <= 1'b0;
        if (tick_1hz && (dwell_q != '0)) dwell_q <= dwell_q - 6'd1;
      end
    end
  end

`ifdef VEH_COUNT_EN
  logic [1:0] arrive;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      arrive[i] = (state_d[i] == PRESENT) &&
                  ((state_q[i] == ABSENT) || (state_q[i] == QUALIFY));
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || cnt_clr) begin
      cnt_main   <= '0;
      cnt_branch <= '0;
    end else begin
      if (arrive[1] && (cnt_main != 8'hFF))   cnt_main   <= cnt_main + 8'd1;
      if (arrive[0] && (cnt_branch != 8'hFF)) cnt_branch <= cnt_branch + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vehicle_demand_detector.sv
// Directed bench for vehicle_demand_detector with a run-length/tick-count reference model.
module tb_vehicle_demand_detector;

  localparam int DEB   = 4;
  localparam int HOLD  = 3;
  localparam int DWELL = 2;
  localparam int STK   = 5;

  logic       sys_clk, sys_rst, tick_1hz, det_main, det_branch, fault_clr, cnt_clr;
  logic [1:0] sw, stuck;
  logic       sw_chg;
  logic [7:0] cnt_main, cnt_branch;

  int n_chk = 0;
  int n_err = 0;

  vehicle_demand_detector #(
    .DEBOUNCE_CYC(DEB), .HOLD_SEC(HOLD), .MIN_DWELL_SEC(DWELL), .STUCK_SEC(STK)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tick_1hz(tick_1hz),
    .det_main(det_main), .det_branch(det_branch), .fault_clr(fault_clr),
`ifdef VEH_COUNT_EN
    .cnt_clr(cnt_clr), .cnt_main(cnt_main), .cnt_branch(cnt_branch),
`endif
    .sw(sw), .sw_chg(sw_chg), .stuck(stuck)
  );

`ifndef VEH_COUNT_EN
  assign cnt_main   = 8'h00;
  assign cnt_branch = 8'h00;
`endif

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic expect_out(input string name, input logic [1:0] e_sw, input logic e_chg,
                            input logic [1:0] e_stk);
    check(name, 32'({sw, sw_chg, stuck}), 32'({e_sw, e_chg, e_stk}));
  endtask

  // Reference model: qualification by run length of the synchronised input,
  // stretch by counting ticks seen while low, stuck by counting ticks while present.
  logic [1:0] m_s1, m_s, m_dem, m_low, m_stk, m_sw;
  logic       m_chg, m_valid = 1'b0;
  int         m_dwell;
  int         run [2];
  int         low_ticks [2];
  int         hi_ticks [2];
  int         m_cnt [2];

  always @(posedge sys_clk) begin : model_and_compare
    logic [1:0] d_old;
    logic [1:0] set_v;
    logic [1:0] arrive;
    if (sys_rst) begin
      m_s1 = '0; m_s = '0; m_dem = '0; m_low = '0; m_stk = '0; m_sw = '0;
      m_chg = 1'b0; m_dwell = 0; m_valid = 1'b1;
      for (int r = 0; r < 2; r++) begin
        run[r] = 0; low_ticks[r] = 0; hi_ticks[r] = 0; m_cnt[r] = 0;
      end
    end else begin
      d_old = m_dem | m_stk;
      m_chg = 1'b0;
      if (d_old != m_sw && m_dwell == 0) begin
        m_sw = d_old; m_chg = 1'b1; m_dwell = DWELL;
      end else if (tick_1hz && m_dwell > 0) begin
        m_dwell = m_dwell - 1;
      end
      set_v = '0;
      arrive = '0;
      for (int r = 0; r < 2; r++) begin
        if (m_s[r]) begin
          run[r] = (run[r] < 1000) ? run[r] + 1 : run[r];
          if (m_dem[r] && !m_low[r]) begin
            if (tick_1hz) begin
              hi_ticks[r] = (hi_ticks[r] < STK) ? hi_ticks[r] + 1 : STK;
              if (hi_ticks[r] >= STK) set_v[r] = 1'b1;
            end
          end else if (m_dem[r]) begin
            m_low[r] = 1'b0; hi_ticks[r] = 0;
          end else if (run[r] >= DEB) begin
            m_dem[r] = 1'b1; hi_ticks[r] = 0; arrive[r] = 1'b1;
          end
        end else begin
          run[r] = 0;
          if (m_dem[r] && !m_low[r]) begin
            m_low[r] = 1'b1; low_ticks[r] = 0;
          end else if (m_dem[r] && tick_1hz) begin
            low_ticks[r] = low_ticks[r] + 1;
            if (low_ticks[r] == HOLD) begin
              m_dem[r] = 1'b0; m_low[r] = 1'b0;
            end
          end
        end
        if (cnt_clr) m_cnt[r] = 0;
        else if (arrive[r] && m_cnt[r] < 255) m_cnt[r] = m_cnt[r] + 1;
      end
      m_stk = set_v | (m_stk & ~{2{fault_clr}});
      m_s   = m_s1;
      m_s1  = {det_main, det_branch};
    end
    #1;
    if (m_valid) begin
      check("outputs_vs_model", 32'({sw, sw_chg, stuck}), 32'({m_sw, m_chg, m_stk}));
`ifdef VEH_COUNT_EN
      check("cnt_main_vs_model", 32'(cnt_main), 32'(m_cnt[1]));
      check("cnt_branch_vs_model", 32'(cnt_branch), 32'(m_cnt[0]));
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic tk();
    tick_1hz = 1'b1;
    @(negedge sys_clk);
    tick_1hz = 1'b0;
  endtask

  task automatic tks(input int n);
    repeat (n) tk();
  endtask

  task automatic main_pulse();
    det_main = 1'b1; cyc(7);
    det_main = 1'b0; cyc(4); tks(3); cyc(2);
  endtask

  initial begin
    sys_rst = 1'b1; tick_1hz = 1'b0; det_main = 1'b0; det_branch = 1'b0;
    fault_clr = 1'b0; cnt_clr = 1'b0;
    cyc(3);
    expect_out("reset_state", 2'b00, 1'b0, 2'b00);
    sys_rst = 1'b0;

    // Debounce latency: rise before edge 0, sw after edge DEB+2
    det_main = 1'b1;
    cyc(6); expect_out("deb_before", 2'b00, 1'b0, 2'b00);
    cyc(1); expect_out("deb_assert", 2'b10, 1'b1, 2'b00);
    cyc(1); expect_out("deb_chg_one_cycle", 2'b10, 1'b0, 2'b00);

    // Short branch glitch is rejected
    det_branch = 1'b1; cyc(3); det_branch = 1'b0; cyc(10);
    expect_out("glitch_reject", 2'b10, 1'b0, 2'b00);

    // Hold stretch across three ticks
    det_main = 1'b0; cyc(4);
    tk(); cyc(3); expect_out("hold_tick1", 2'b10, 1'b0, 2'b00);
    tk(); cyc(3); expect_out("hold_tick2", 2'b10, 1'b0, 2'b00);
    tk();         expect_out("hold_tick3_edge", 2'b10, 1'b0, 2'b00);
    cyc(1);       expect_out("hold_release", 2'b00, 1'b1, 2'b00);

    // Re-assert during hold keeps demand with no sw change
    tks(2);
    det_main = 1'b1; cyc(8); expect_out("reassert_up", 2'b10, 1'b0, 2'b00);
    det_main = 1'b0; cyc(4); tks(2);
    det_main = 1'b1; cyc(4); tks(4);
    expect_out("reassert_kept", 2'b10, 1'b0, 2'b00);
    det_main = 1'b0; cyc(4); tks(3); cyc(2);
    expect_out("reassert_release", 2'b00, 1'b0, 2'b00);

    // Minimum dwell delays the second change; both bits fall together
    tks(2);
    det_branch = 1'b1; cyc(7); expect_out("dwell_first", 2'b01, 1'b1, 2'b00);
    det_main = 1'b1; cyc(10); expect_out("dwell_blocked", 2'b01, 1'b0, 2'b00);
    tk(); cyc(2); tk();       expect_out("dwell_expiring", 2'b01, 1'b0, 2'b00);
    cyc(1);                   expect_out("dwell_second", 2'b11, 1'b1, 2'b00);
    det_main = 1'b0; det_branch = 1'b0; cyc(4); tks(3);
    expect_out("both_hold", 2'b11, 1'b0, 2'b00);
    cyc(1); expect_out("both_fall_together", 2'b00, 1'b1, 2'b00);

    // Stuck detection, forced demand, clear
    tks(2);
    det_branch = 1'b1; cyc(7); tks(4);
    expect_out("stuck_not_yet", 2'b01, 1'b0, 2'b00);
    tk(); expect_out("stuck_set", 2'b01, 1'b0, 2'b01);
    det_branch = 1'b0; cyc(4); tks(3); cyc(3);
    expect_out("stuck_forces_demand", 2'b01, 1'b0, 2'b01);
    fault_clr = 1'b1; cyc(1); fault_clr = 1'b0;
    expect_out("stuck_cleared", 2'b01, 1'b0, 2'b00);
    cyc(1); expect_out("stuck_release_sw", 2'b00, 1'b1, 2'b00);

    // Set wins over a simultaneous clear
    tks(2);
    det_branch = 1'b1; cyc(7); tks(4);
    tick_1hz = 1'b1; fault_clr = 1'b1; cyc(1); tick_1hz = 1'b0; fault_clr = 1'b0;
    expect_out("set_beats_clear", 2'b01, 1'b0, 2'b01);
    fault_clr = 1'b1; cyc(1); fault_clr = 1'b0;
    expect_out("clear_alone", 2'b01, 1'b0, 2'b00);
    det_branch = 1'b0; cyc(4); tks(3); cyc(2);
    expect_out("branch_released", 2'b00, 1'b0, 2'b00);

    // Reset together with fault_clr in the middle of hold
    tks(2);
    det_main = 1'b1; cyc(8); expect_out("pre_reset_up", 2'b10, 1'b0, 2'b00);
    det_main = 1'b0; cyc(4); tk();
    sys_rst = 1'b1; fault_clr = 1'b1; cyc(1);
    expect_out("reset_mid_hold", 2'b00, 1'b0, 2'b00);
    sys_rst = 1'b0; fault_clr = 1'b0; cyc(6);
    expect_out("after_reset_idle", 2'b00, 1'b0, 2'b00);

`ifdef VEH_COUNT_EN
    cnt_clr = 1'b1; cyc(1); cnt_clr = 1'b0;
    check("cnt_cleared", 32'(cnt_main), 32'd0);
    repeat (3) main_pulse();
    check("cnt_three", 32'(cnt_main), 32'd3);
    check("cnt_branch_zero", 32'(cnt_branch), 32'd0);
    repeat (300) main_pulse();
    check("cnt_saturate", 32'(cnt_main), 32'd255);
    det_main = 1'b1; cyc(5);
    cnt_clr = 1'b1; cyc(1); cnt_clr = 1'b0;
    check("cnt_clr_beats_inc", 32'(cnt_main), 32'd0);
    cyc(3);
    check("cnt_clr_held", 32'(cnt_main), 32'd0);
    det_main = 1'b0; cyc(4); tks(3); cyc(2);
`else
    main_pulse();
    expect_out("pulse_idle", 2'b00, 1'b0, 2'b00);
`endif

    cyc(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
